dct_block_ctrl: RTL and testbench

//   Sequencer for the 8x8 2-D DCT datapath (dct_2d_8x8).
//   - Collects 64 input samples from a valid/ready stream into one 8x8 block.
//   - Presents the block to the datapath and waits a fixed latency.
//   - Captures the 64 coefficients and streams them out with a last marker.
//   - Sits between the pixel front-end and the quantiser. One block in flight.

---
 rtl/dct_block_ctrl.sv | 134 +++++++++++++
 tb/tb_dct_block_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct_block_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dct_block_ctrl
// Brief    : Block sequencer for the 8x8 2-D DCT datapath. It collects 64
//            raster-order samples into one buffer and presents them to the
//            datapath. After a fixed latency it captures the 64 coefficients
//            into the same buffer and streams them out with a last marker.
//            Only one block is in flight at a time.
// Options  : DCT_LEVEL_SHIFT_EN - subtract (128 << FRAC_BITS) from each
//            accepted sample (JPEG level shift). Undefined: samples verbatim.
// Revision : 1.0 - initial release
// ============================================================================
module dct_block_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int FRAC_BITS   = 16,
  parameter int DCT_LATENCY = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_WIDTH-1:0]    s_data,
  output logic [64*DATA_WIDTH-1:0] dct_in_matrix,
  input  logic [64*DATA_WIDTH-1:0] dct_out_matrix,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DATA_WIDTH-1:0]    m_data,
  output logic                     m_last,
  output logic                     busy,
  output logic [CNT_WIDTH-1:0]     blocks_done
);

  localparam int                 LAT_W      = $clog2(DCT_LATENCY + 1);
  localparam logic [LAT_W-1:0]   c_LAT_INIT = LAT_W'(DCT_LATENCY);
  localparam logic [LAT_W-1:0]   c_LAT_ONE  = LAT_W'(1);
  localparam logic [5:0]         c_IDX_LAST = 6'd63;

  typedef enum logic [1:0] {
    ST_FILL    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

  state_t                 r_state;
  logic [5:0]             r_idx;
  logic [LAT_W-1:0]       r_lat;
  logic [DATA_WIDTH-1:0]  r_buf [64];
  logic                   r_s_ready;
  logic                   r_m_valid;
  logic [CNT_WIDTH-1:0]   r_blocks_done;
  logic [DATA_WIDTH-1:0]  w_sample;

  // Sample conditioning on the way into the buffer
`ifdef DCT_LEVEL_SHIFT_EN
  localparam logic [DATA_WIDTH-1:0] c_LEVEL = DATA_WIDTH'(128) << FRAC_BITS;
  assign w_sample = s_data - c_LEVEL;
`else
  assign w_sample = s_data;
`endif

  // The buffer drives the datapath input directly; frozen outside FILL
  generate
    for (genvar g = 0; g < 64; g++) begin : g_pack
      assign dct_in_matrix[g*DATA_WIDTH +: DATA_WIDTH] = r_buf[g];
    end
  endgenerate

  assign s_ready     = r_s_ready;
  assign m_valid     = r_m_valid;
  assign m_data      = r_m_valid ? r_buf[r_idx] : '0;
  assign m_last      = r_m_valid && (r_idx == c_IDX_LAST);
  assign busy        = (r_state != ST_FILL);
  assign blocks_done = r_blocks_done;

  // Block sequencer: fill, wait for the datapath, capture, drain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_FILL;
      r_idx         <= 6'd0;
      r_lat         <= '0;
      r_s_ready     <= 1'b1;
      r_m_valid     <= 1'b0;
      r_blocks_done <= '0;
      for (int k = 0; k < 64; k++) r_buf[k] <= '0;
    end else begin
      case (r_state)
        ST_FILL: begin
          if (s_valid && r_s_ready) begin
            r_buf[r_idx] <= w_sample;
            if (r_idx == c_IDX_LAST) begin
              r_idx     <= 6'd0;
              r_lat     <= c_LAT_INIT;
              r_s_ready <= 1'b0;
              r_state   <= ST_COMPUTE;
            end else begin
              r_idx <= r_idx + 6'd1;
            end
          end
        end
        ST_COMPUTE: begin
          r_lat <= r_lat - c_LAT_ONE;
          if (r_lat == c_LAT_ONE) begin
            for (int k = 0; k < 64; k++)
              r_buf[k] <= dct_out_matrix[k*DATA_WIDTH +: DATA_WIDTH];
            r_m_valid <= 1'b1;
            r_state   <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (r_m_valid && m_ready) begin
            if (r_idx == c_IDX_LAST) begin
              r_idx         <= 6'd0;
              r_blocks_done <= r_blocks_done + 1'b1;
              r_m_valid     <= 1'b0;
              r_s_ready     <= 1'b1;
              r_state       <= ST_FILL;
            end else begin
              r_idx <= r_idx + 6'd1;
            end
          end
        end
        default: begin
          r_state   <= ST_FILL;
          r_idx     <= 6'd0;
          r_s_ready <= 1'b1;
          r_m_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dct_block_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dct_block_ctrl
// Brief    : Directed bench for dct_block_ctrl with a simple datapath model
//            (word 0 = sum of inputs, word k = in[k]-in[k-1], DCT_LATENCY-1
//            register stages). It honours DCT_LEVEL_SHIFT_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dct_block_ctrl;

  localparam int DW  = 32;
  localparam int FB  = 16;
  localparam int LAT = 2;
  localparam int CW  = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [DW-1:0]   s_data = '0;
  logic [64*DW-1:0] dct_in;
  logic [64*DW-1:0] dct_out = '0;
  logic            m_valid;
  logic            m_ready = 1'b0;
  logic [DW-1:0]   m_data;
  logic            m_last;
  logic            busy;
  logic [CW-1:0]   blocks_done;

  int checks = 0;
  int errors = 0;
  int cyc_now = 0;
  int acc_cyc, mv_cyc, hold_viol, mv_in_fill, timeout;
  logic [DW-1:0]    samp [64];
  logic [DW-1:0]    got [64];
  logic             got_last [64];
  logic [64*DW-1:0] exp_v;

  always #5 clk = ~clk;

  dct_block_ctrl #(
    .DATA_WIDTH(DW), .FRAC_BITS(FB), .DCT_LATENCY(LAT), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .dct_in_matrix(dct_in), .dct_out_matrix(dct_out),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .blocks_done(blocks_done)
  );

  function automatic logic [64*DW-1:0] dct_model(input logic [64*DW-1:0] x);
    logic [64*DW-1:0] y;
    logic [DW-1:0] acc;
    acc = '0;
    for (int k = 0; k < 64; k++) acc = acc + x[k*DW +: DW];
    y[0 +: DW] = acc;
    for (int k = 1; k < 64; k++) y[k*DW +: DW] = x[k*DW +: DW] - x[(k-1)*DW +: DW];
    return y;
  endfunction

  function automatic logic [DW-1:0] lshift(input logic [DW-1:0] x);
`ifdef DCT_LEVEL_SHIFT_EN
    logic [DW-1:0] c;
    c = DW'(128) << FB;
    return x - c;
`else
    return x;
`endif
  endfunction

  function automatic logic [64*DW-1:0] packed_in();
    logic [64*DW-1:0] v;
    for (int k = 0; k < 64; k++) v[k*DW +: DW] = lshift(samp[k]);
    return v;
  endfunction

  // Datapath model: LAT-1 register stages so data is valid on the LAT-th edge
  always @(posedge clk) dct_out <= dct_model(dct_in);
  always @(posedge clk) cyc_now <= cyc_now + 1;

  task automatic do_reset();
    reset = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic fill(input int n, input int gap_pct);
    int k, cyc;
    logic acc;
    k = 0; cyc = 0; mv_in_fill = 0; timeout = 0;
    while (k < n && cyc < 5000) begin
      @(negedge clk);
      if (m_valid) mv_in_fill++;
      s_valid = ($urandom_range(99) >= gap_pct);
      s_data  = s_valid ? samp[k] : DW'($urandom());
      acc = s_valid && s_ready;
      @(posedge clk);
      cyc++;
      if (acc) k++;
    end
    @(negedge clk);
    s_valid = 1'b0;
    acc_cyc = cyc_now;
    if (k < n) timeout = 1;
  endtask

  task automatic drain(input int n, input int stall_pct);
    int cnt, cyc;
    logic prev_stall, pl;
    logic [DW-1:0] pd;
    cnt = 0; cyc = 0; prev_stall = 1'b0; pd = '0; pl = 1'b0;
    hold_viol = 0; mv_cyc = -1;
    while (cnt < n && cyc < 5000) begin
      @(negedge clk);
      if (m_valid) begin
        if (mv_cyc < 0) mv_cyc = cyc_now;
        if (prev_stall && (m_data !== pd || m_last !== pl)) hold_viol++;
        pd = m_data; pl = m_last;
      end
      m_ready = ($urandom_range(99) >= stall_pct);
      prev_stall = m_valid && !m_ready;
      if (m_valid && m_ready) begin
        got[cnt] = m_data; got_last[cnt] = m_last; cnt++;
      end
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    m_ready = 1'b0;
    if (cnt < n) timeout = 1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b expected 1", s_ready); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
    checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last: got %b expected 0", m_last); end
    checks++; if (m_data !== '0) begin errors++; $display("FAIL reset_m_data: got %h expected 0", m_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (blocks_done !== '0) begin errors++; $display("FAIL reset_blocks_done: got %0d expected 0", blocks_done); end
    checks++; if (dct_in !== '0) begin errors++; $display("FAIL reset_dct_in: not all zero"); end
  endtask

  task automatic test_single_block();
    do_reset();
    for (int k = 0; k < 64; k++) samp[k] = DW'(k) << FB;
    exp_v = dct_model(packed_in());
    fill(64, 0);
    checks++; if (s_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_after_fill: s_ready=%b busy=%b expected 0/1", s_ready, busy); end
    checks++; if (dct_in !== packed_in()) begin errors++; $display("FAIL single_dct_in: buffer does not hold the block"); end
    drain(64, 0);
    checks++; if (timeout != 0) begin errors++; $display("FAIL single_timeout: got %0d expected 0", timeout); end
    checks++; if (mv_cyc - acc_cyc != LAT) begin errors++; $display("FAIL single_latency: got %0d expected %0d", mv_cyc - acc_cyc, LAT); end
    for (int k = 0; k < 64; k++) begin
      checks++; if (got[k] !== exp_v[k*DW +: DW]) begin errors++; $display("FAIL single_data[%0d]: got %h expected %h", k, got[k], exp_v[k*DW +: DW]); end
      checks++; if (got_last[k] !== (k == 63)) begin errors++; $display("FAIL single_last[%0d]: got %b expected %b", k, got_last[k], (k == 63)); end
    end
    checks++; if (blocks_done !== 2'd1) begin errors++; $display("FAIL single_blocks_done: got %0d expected 1", blocks_done); end
    checks++; if (s_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL single_back_to_fill: s_ready=%b busy=%b expected 1/0", s_ready, busy); end
  endtask

  task automatic test_stalls();
    int bad;
    do_reset();
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < 64; k++) samp[k] = DW'($urandom());
      exp_v = dct_model(packed_in());
      fill(64, 50);
      drain(64, 50);
      bad = 0;
      for (int k = 0; k < 64; k++) if (got[k] !== exp_v[k*DW +: DW] || got_last[k] !== (k == 63)) bad++;
      checks++; if (timeout != 0) begin errors++; $display("FAIL stall_timeout blk%0d: got %0d expected 0", b, timeout); end
      checks++; if (bad != 0) begin errors++; $display("FAIL stall_data blk%0d: got %0d bad words expected 0", b, bad); end
      checks++; if (hold_viol != 0) begin errors++; $display("FAIL stall_hold blk%0d: got %0d changes expected 0", b, hold_viol); end
      checks++; if (blocks_done !== CW'(b + 1)) begin errors++; $display("FAIL stall_blocks_done blk%0d: got %0d expected %0d", b, blocks_done, b + 1); end
    end
  endtask

  task automatic test_reset_mid_fill();
    int bad;
    do_reset();
    for (int k = 0; k < 64; k++) samp[k] = DW'($urandom());
    fill(40, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 64; k++) samp[k] = DW'($urandom());
    exp_v = dct_model(packed_in());
    fill(64, 0);
    checks++; if (mv_in_fill != 0) begin errors++; $display("FAIL midfill_m_valid: got %0d valid cycles expected 0", mv_in_fill); end
    drain(64, 0);
    bad = 0;
    for (int k = 0; k < 64; k++) if (got[k] !== exp_v[k*DW +: DW]) bad++;
    checks++; if (bad != 0 || timeout != 0) begin errors++; $display("FAIL midfill_data: got %0d bad words timeout=%0d expected 0", bad, timeout); end
    checks++; if (blocks_done !== 2'd1) begin errors++; $display("FAIL midfill_blocks_done: got %0d expected 1", blocks_done); end
  endtask

  task automatic test_reset_in_drain();
    do_reset();
    for (int k = 0; k < 64; k++) samp[k] = DW'($urandom());
    exp_v = dct_model(packed_in());
    fill(64, 0);
    drain(10, 0);
    checks++; if (m_valid !== 1'b1 || m_data !== exp_v[10*DW +: DW]) begin errors++; $display("FAIL drain_idx10: valid=%b data=%h expected 1/%h", m_valid, m_data, exp_v[10*DW +: DW]); end
    #1 reset = 1'b1;
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL drainrst_m_valid: got %b expected 0", m_valid); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL drainrst_s_ready: got %b expected 1", s_ready); end
    checks++; if (blocks_done !== '0 || busy !== 1'b0) begin errors++; $display("FAIL drainrst_state: blocks_done=%0d busy=%b expected 0/0", blocks_done, busy); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_counter_wrap();
    logic [CW-1:0] exp_cnt [4];
    exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd0;
    do_reset();
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 64; k++) samp[k] = DW'($urandom());
      fill(64, 0);
      drain(64, 0);
      checks++; if (blocks_done !== exp_cnt[b]) begin errors++; $display("FAIL wrap_blocks_done blk%0d: got %0d expected %0d", b, blocks_done, exp_cnt[b]); end
    end
  endtask

  task automatic test_level_shift();
    logic [DW-1:0] exp_in, exp_dc;
    int bad_in, bad_ac;
`ifdef DCT_LEVEL_SHIFT_EN
    exp_in = 32'h0000_0000; exp_dc = 32'h0000_0000;
`else
    exp_in = 32'h0080_0000; exp_dc = 32'h2000_0000;
`endif
    do_reset();
    for (int k = 0; k < 64; k++) samp[k] = 32'h0080_0000;
    fill(64, 0);
    bad_in = 0;
    for (int k = 0; k < 64; k++) if (dct_in[k*DW +: DW] !== exp_in) bad_in++;
    checks++; if (bad_in != 0) begin errors++; $display("FAIL shift_dct_in: got %0d words differing from %h expected 0", bad_in, exp_in); end
    drain(64, 0);
    checks++; if (got[0] !== exp_dc) begin errors++; $display("FAIL shift_dc: got %h expected %h", got[0], exp_dc); end
    bad_ac = 0;
    for (int k = 1; k < 64; k++) if (got[k] !== '0) bad_ac++;
    checks++; if (bad_ac != 0 || timeout != 0) begin errors++; $display("FAIL shift_ac: got %0d nonzero AC timeout=%0d expected 0", bad_ac, timeout); end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_stalls();
    test_reset_mid_fill();
    test_reset_in_drain();
    test_counter_wrap();
    test_level_shift();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
